// File: rtl/slow_peripheral_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slow_peripheral_pkg
//  Description : Shared widths, FSM encoding and counter width for the slow
//                peripheral responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package slow_peripheral_pkg;

    // Default bus geometry
    localparam int c_DEF_DATA_W = 32;
    localparam int c_DEF_ADDR_W = 4;

    // Width of the accepted-write counter exposed at the top address
    localparam int c_WRITE_COUNT_W = 32;

    // Command-acceptance FSM encoding
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage : slow_peripheral_pkg
`default_nettype wire

// File: rtl/slow_peripheral_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : slow_peripheral_responder_if
//  Description : Avalon-MM pipelined bus bundle between a master and the
//                slow peripheral responder.
//  Revision    : 1.0 - initial release
// ============================================================================
interface slow_peripheral_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                endofpacket;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid, endofpacket
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid, endofpacket
    );
endinterface : slow_peripheral_responder_if
`default_nettype wire

// File: rtl/slow_peripheral_responder_rdpipe.sv
`default_nettype none
// ============================================================================
//  Module      : slow_peripheral_responder_rdpipe
//  Description : Fixed-latency read response pipeline carrying
//                {valid, eop, data}. Data and eop are forced to zero in any
//                stage that holds no response, so the output is clean when
//                readdatavalid is low. Reset flushes every stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module slow_peripheral_responder_rdpipe #(
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 3
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_valid,
    input  wire logic              i_eop,
    input  wire logic [DATA_W-1:0] i_data,
    output logic                   o_valid,
    output logic                   o_eop,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_ret_next
);

    logic [READ_LATENCY-1:0] r_valid;
    logic [READ_LATENCY-1:0] r_eop;
    logic [DATA_W-1:0]       r_data [READ_LATENCY];

    // Shift responses one stage per cycle; flush on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_eop   <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_valid[0] <= i_valid;
            r_eop[0]   <= i_valid & i_eop;
            r_data[0]  <= i_valid ? i_data : '0;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_eop[s]   <= r_eop[s-1];
                r_data[s]  <= r_data[s-1];
            end
        end
    end

    assign o_valid = r_valid[READ_LATENCY-1];
    assign o_eop   = r_eop[READ_LATENCY-1];
    assign o_data  = r_data[READ_LATENCY-1];

    // o_ret_next flags a response that will be presented on the output next
    // cycle; the parent retires its pending count on that edge.
    generate
        if (READ_LATENCY == 1) begin : g_ret_lat1
            assign o_ret_next = i_valid;
        end else begin : g_ret_latn
            assign o_ret_next = r_valid[READ_LATENCY-2];
        end
    endgenerate

endmodule : slow_peripheral_responder_rdpipe
`default_nettype wire

// File: rtl/slow_peripheral_responder.sv
`default_nettype none
// ============================================================================
//  Module      : slow_peripheral_responder
//  Description : Avalon-MM pipelined slave modelling a slow register-mapped
//                peripheral: programmable wait states, byte-enabled register
//                file, read-only write counter at the top address, fixed read
//                latency with a bounded number of outstanding reads and
//                endofpacket tagging of one address.
//  Revision    : 1.0 - initial release
// ============================================================================
module slow_peripheral_responder
    import slow_peripheral_pkg::*;
#(
    parameter int DATA_W       = c_DEF_DATA_W,
    parameter int ADDR_W       = c_DEF_ADDR_W,
    parameter int WAIT_STATES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 2,
    parameter int EOP_ADDR     = (2**ADDR_W) - 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    slow_peripheral_responder_if.slave bus
);

    localparam int                c_BYTES    = DATA_W / 8;
    localparam int                c_DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] c_RO_ADDR  = ADDR_W'(c_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_EOP_ADDR = ADDR_W'(EOP_ADDR);
    localparam logic [3:0]        c_WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [3:0]        c_MAX_PEND = 4'(MAX_PENDING);

    state_t                     r_state;
    state_t                     w_state_next;
    logic [3:0]                 r_ws_cnt;
    logic [3:0]                 w_ws_cnt_next;
    logic [3:0]                 r_pending;
    logic [c_WRITE_COUNT_W-1:0] r_write_count;
    logic [DATA_W-1:0]          r_regs [c_DEPTH];

    logic              w_cmd;
    logic              w_accept;
    logic              w_pend_full;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ret;
    logic              w_rd_eop;
    logic [DATA_W-1:0] w_count_ext;
    logic [DATA_W-1:0] w_rd_data;

    // A simultaneous read and write is handled as a write
    assign w_cmd       = bus.read | bus.write;
    assign w_pend_full = (r_pending >= c_MAX_PEND);
    assign w_wr_acc    = w_accept & bus.write;
    assign w_rd_acc    = w_accept & bus.read & ~bus.write;

    // FSM register and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_ws_cnt <= 4'd0;
        end else begin
            r_state  <= w_state_next;
            r_ws_cnt <= w_ws_cnt_next;
        end
    end

    // Next-state and acceptance decode
    always_comb begin
        w_state_next  = r_state;
        w_ws_cnt_next = r_ws_cnt;
        w_accept      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd) begin
                    if (WAIT_STATES == 0) begin
                        if (!w_pend_full) begin
                            w_accept = 1'b1;
                        end
                    end else begin
                        w_state_next  = ST_WAIT;
                        w_ws_cnt_next = c_WS_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!w_cmd) begin
                    // Master withdrew the command: abandon it silently
                    w_state_next = ST_IDLE;
                end else if (r_ws_cnt != 4'd0) begin
                    w_ws_cnt_next = r_ws_cnt - 4'd1;
                end else if (!w_pend_full) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.waitrequest = w_cmd & ~w_accept;

    // Byte-lane register writes; the top address is read-only
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < c_DEPTH; w++) begin
                r_regs[w] <= '0;
            end
        end else if (w_wr_acc && (bus.address != c_RO_ADDR)) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (bus.byteenable[b]) begin
                    r_regs[bus.address][b*8 +: 8] <= bus.writedata[b*8 +: 8];
                end
            end
        end
    end

    // Count every accepted write, including those to the read-only address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_count <= '0;
        end else if (w_wr_acc) begin
            r_write_count <= r_write_count + 1'b1;
        end
    end

    // Read data is taken from current register state, before this edge's write
    assign w_count_ext = DATA_W'(r_write_count);
    assign w_rd_data   = (bus.address == c_RO_ADDR) ? w_count_ext : r_regs[bus.address];
    assign w_rd_eop    = (bus.address == c_EOP_ADDR);

    // Outstanding reads: a read leaves the count on the edge that raises its
    // readdatavalid, so the registered count alone gates acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= 4'd0;
        end else begin
            case ({w_rd_acc, w_ret})
                2'b10:   r_pending <= r_pending + 4'd1;
                2'b01:   r_pending <= r_pending - 4'd1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    slow_peripheral_responder_rdpipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rdpipe (
        .clk        (clk),
        .reset      (reset),
        .i_valid    (w_rd_acc),
        .i_eop      (w_rd_eop),
        .i_data     (w_rd_data),
        .o_valid    (bus.readdatavalid),
        .o_eop      (bus.endofpacket),
        .o_data     (bus.readdata),
        .o_ret_next (w_ret)
    );

endmodule : slow_peripheral_responder
`default_nettype wire

// File: tb/tb_slow_peripheral_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_slow_peripheral_responder
//  Description : Directed self-checking bench. Three responders are built:
//                defaults (u_dut0), zero wait states with two outstanding
//                reads (u_dut1), and zero wait states with three outstanding
//                reads (u_dut2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slow_peripheral_responder;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    slow_peripheral_responder_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
    slow_peripheral_responder_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();
    slow_peripheral_responder_if #(.DATA_W(32), .ADDR_W(4)) bus2 ();

    slow_peripheral_responder #(
        .DATA_W(32), .ADDR_W(4), .WAIT_STATES(2), .READ_LATENCY(3), .MAX_PENDING(2), .EOP_ADDR(14)
    ) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

    slow_peripheral_responder #(
        .DATA_W(32), .ADDR_W(4), .WAIT_STATES(0), .READ_LATENCY(3), .MAX_PENDING(2), .EOP_ADDR(14)
    ) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

    slow_peripheral_responder #(
        .DATA_W(32), .ADDR_W(4), .WAIT_STATES(0), .READ_LATENCY(3), .MAX_PENDING(3), .EOP_ADDR(14)
    ) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one command on bus0 until accepted; returns stall cycles seen.
    // Entered and left just after a rising edge.
    task automatic cmd0(input bit wr, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int waits);
        bus0.address    = a;
        bus0.writedata  = d;
        bus0.byteenable = be;
        bus0.write      = wr;
        bus0.read       = !wr;
        waits = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!bus0.waitrequest) break;
            waits++;
        end
        @(posedge clk);
        #1;
        bus0.read  = 1'b0;
        bus0.write = 1'b0;
    endtask

    // Wait for the next response on bus0; lat counts cycles after acceptance.
    task automatic rsp0(output logic [31:0] d, output logic eop, output int lat);
        lat = 0;
        d   = '0;
        eop = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus0.readdatavalid) begin
                lat = k;
                d   = bus0.readdata;
                eop = bus0.endofpacket;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic read0(input logic [3:0] a, output logic [31:0] d, output logic eop,
                         output int waits, output int lat);
        cmd0(1'b0, a, 32'h0, 4'h0, waits);
        rsp0(d, eop, lat);
    endtask

    task automatic write0(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                          output int waits);
        cmd0(1'b1, a, d, be, waits);
    endtask

    initial begin
        int          waits;
        int          lat;
        int          cnt;
        logic [31:0] d;
        logic        eop;
        logic [11:0] wr_v1;
        logic [11:0] rdv_v1;
        logic [23:0] rdv_v2;
        logic [23:0] eop_v2;
        int          wr_cnt2;
        int          dirty2;

        bus0.address = '0; bus0.byteenable = '0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.writedata = '0;
        bus1.address = '0; bus1.byteenable = '0; bus1.read = 1'b0; bus1.write = 1'b0; bus1.writedata = '0;
        bus2.address = '0; bus2.byteenable = '0; bus2.read = 1'b0; bus2.write = 1'b0; bus2.writedata = '0;

        // ---------------- reset state ----------------
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_waitrequest", {63'd0, bus0.waitrequest}, 64'd0);
        check("rst_rdvalid",     {63'd0, bus0.readdatavalid}, 64'd0);
        check("rst_readdata",    {32'd0, bus0.readdata}, 64'd0);
        check("rst_eop",         {63'd0, bus0.endofpacket}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ---------------- pending throttle (WS=0, MP=2, RL=3) ----------------
        bus1.address = 4'd0;
        bus1.read    = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            wr_v1[k]  = bus1.waitrequest;
            rdv_v1[k] = bus1.readdatavalid;
        end
        @(posedge clk);
        #1;
        bus1.read = 1'b0;
        // accepts at 0,1,3,4,6,7,9,10 ; responses three cycles after each
        check("throttle_waitrequest", {52'd0, wr_v1}, 64'h924);
        check("throttle_rdvalid",     {52'd0, rdv_v1}, 64'h6D8);

        // ---------------- full throughput + EOP (WS=0, MP=3) ----------------
        wr_cnt2 = 0;
        dirty2  = 0;
        bus2.address = 4'd14;
        bus2.read    = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 16) begin
                @(posedge clk);
                #1;
                bus2.read = 1'b0;
            end
            @(negedge clk);
            if (bus2.waitrequest) wr_cnt2++;
            rdv_v2[k] = bus2.readdatavalid;
            eop_v2[k] = bus2.endofpacket;
            if (!bus2.readdatavalid && (bus2.readdata != 32'd0)) dirty2++;
        end
        @(posedge clk);
        #1;
        check("tput_waitrequest_cnt", 64'(wr_cnt2), 64'd0);
        check("tput_rdvalid",         {40'd0, rdv_v2}, 64'h7FFF8);
        check("tput_eop",             {40'd0, eop_v2}, 64'h7FFF8);
        check("tput_idle_data_zero",  64'(dirty2), 64'd0);

        // ---------------- wait-state timing (defaults) ----------------
        write0(4'd3, 32'hDEADBEEF, 4'hF, waits);
        check("ws_write_stalls", 64'(waits), 64'd2);
        read0(4'd3, d, eop, waits, lat);
        check("ws_read_stalls", 64'(waits), 64'd2);
        check("ws_read_latency", 64'(lat), 64'd3);
        check("ws_read_data", {32'd0, d}, 64'hDEADBEEF);
        check("ws_read_eop", {63'd0, eop}, 64'd0);

        // ---------------- byte lanes ----------------
        write0(4'd5, 32'h11223344, 4'hF, waits);
        write0(4'd5, 32'hAABBCCDD, 4'h5, waits);
        read0(4'd5, d, eop, waits, lat);
        check("bytelane_data", {32'd0, d}, 64'h11BB33DD);

        // ---------------- reset mid-operation ----------------
        write0(4'd1, 32'h00000055, 4'hF, waits);
        cmd0(1'b0, 4'd1, 32'h0, 4'h0, waits);   // read now in flight
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus0.readdatavalid) cnt++;
        end
        check("rst_mid_no_rdvalid", 64'(cnt), 64'd0);
        check("rst_mid_waitrequest", {63'd0, bus0.waitrequest}, 64'd0);
        @(posedge clk);
        #1;
        read0(4'd1, d, eop, waits, lat);
        check("rst_mid_read_latency", 64'(lat), 64'd3);
        check("rst_mid_read_data", {32'd0, d}, 64'd0);

        // ---------------- read-only write counter ----------------
        write0(4'd0,  32'h00000010, 4'hF, waits);
        write0(4'd1,  32'h00000020, 4'hF, waits);
        write0(4'd15, 32'hFFFFFFFF, 4'hF, waits);
        write0(4'd2,  32'h00000030, 4'hF, waits);
        write0(4'd4,  32'h00000040, 4'hF, waits);
        read0(4'd15, d, eop, waits, lat);
        check("ro_write_count", {32'd0, d}, 64'd5);
        read0(4'd2, d, eop, waits, lat);
        check("ro_neighbour_data", {32'd0, d}, 64'h30);
        read0(4'd14, d, eop, waits, lat);
        check("eop_addr14_default", {63'd0, eop}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_slow_peripheral_responder
`default_nettype wire
